// File: rtl/dmem_pkg.sv
// Shared types and sizing for the block data memory.
package dmem_pkg;

   localparam int unsigned BLOCK_ADDR_W    = 6;
   localparam int unsigned BLOCK_W         = 32;
   localparam int unsigned DEPTH           = 64;
   localparam int unsigned DEFAULT_LATENCY = 5;
   localparam int unsigned COUNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_delay_counter.sv
// Latency countdown: loads a start value, counts down to zero, then holds.
module dmem_delay_counter
   import dmem_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic [COUNT_W-1:0] load_value,
   input  logic               enable,
   output logic               zero
);

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;

   // Next count: load wins, otherwise step down and stop at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (enable && (count_q != '0)) begin
         count_d = count_q - COUNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-granular data memory behind the data cache: fixed-latency read/write-back.
module block_data_memory
   import dmem_pkg::*;
#(
   parameter int unsigned LATENCY = DEFAULT_LATENCY
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    read,
   input  logic                    write,
   input  logic [BLOCK_ADDR_W-1:0] address,
   input  logic [BLOCK_W-1:0]      writedata,
   output logic [BLOCK_W-1:0]      readdata,
   output logic                    busywait,
   output logic                    error
);

   state_t                  state_q, state_d;
   logic                    op_write_q, op_write_d;
   logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
   logic [BLOCK_W-1:0]      wdata_q, wdata_d;
   logic [BLOCK_W-1:0]      rdata_q, rdata_d;
   logic                    error_q, error_d;
   logic [BLOCK_W-1:0]      mem_q [DEPTH];
   logic [BLOCK_W-1:0]      mem_d [DEPTH];

   logic one_request;
   logic cnt_load;
   logic cnt_enable;
   logic cnt_zero;

   assign one_request = read ^ write;
   assign cnt_load    = (state_q == IDLE) && one_request;
   assign cnt_enable  = (state_q == ACCESS);

   dmem_delay_counter u_delay (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (COUNT_W'(LATENCY - 1)),
      .enable     (cnt_enable),
      .zero       (cnt_zero)
   );

   // Next-state, request capture and access completion.
   always_comb begin
      state_d    = state_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      error_d    = 1'b0;
      mem_d      = mem_q;
      unique case (state_q)
         IDLE: begin
            if (one_request) begin
               op_write_d = write;
               addr_d     = address;
               wdata_d    = writedata;
               state_d    = ACCESS;
            end
            error_d = read & write;
         end
         ACCESS: begin
            if (cnt_zero) begin
               if (op_write_q) begin
                  mem_d[addr_q] = wdata_q;
               end else begin
                  rdata_d = mem_q[addr_q];
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured request, outputs and array; reset clears everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         error_q    <= error_d;
         mem_q      <= mem_d;
      end
   end

   assign readdata = rdata_q;
   assign error    = error_q;
   assign busywait = ((state_q == IDLE) && one_request) || (state_q == ACCESS);

endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 5, access latency in clock cycles; legal range 2..15.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port read  input  1  block read request from the data cache controller.
REQ-005 SHALL have port write  input  1  block write-back request from the data cache controller.
REQ-006 SHALL have port address  input  6  block address {tag[2:0], index[2:0]}.
REQ-007 SHALL have port writedata  input  32  write-back block; byte 0 in bits [7:0].
REQ-008 SHALL have port readdata  output  32  fetched block, registered.
REQ-009 SHALL have port busywait  output  1  high while a request is pending or in progress.
REQ-010 SHALL have port error  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-011 SHALL hold a 64-entry x 32-bit block array.
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-013 IDLE: at a rising edge with read XOR write high, SHALL capture op, address and writedata, load the counter with LATENCY-1 and go to ACCESS.
REQ-014 ACCESS: SHALL decrement the counter each edge; at the edge where the counter is 0 it SHALL perform the access and go to DONE.
REQ-015 SHALL enter DONE exactly LATENCY edges after the capture edge.
REQ-016 Read completion: readdata SHALL take the array entry at the captured address; the array SHALL be unchanged.
REQ-017 Write completion: the array entry at the captured address SHALL take the captured writedata; readdata SHALL be unchanged.
REQ-018 DONE: SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 busywait SHALL be combinational: (IDLE & (read XOR write)) | ACCESS; it SHALL be low in DONE.
REQ-020 readdata SHALL hold its value until the next read completes.
REQ-021 Changes on address, writedata, read or write during ACCESS or DONE SHALL be ignored.
REQ-022 A request still asserted when the FSM returns to IDLE SHALL be taken as a new request.
REQ-023 read and write both high in IDLE SHALL cause no capture, no array change and busywait low; error SHALL pulse high for one cycle per offending edge.
REQ-024 The counter SHALL be 4 bits wide; LATENCY-1 SHALL always fit, so it never wraps.

Reset
REQ-025 With reset high at an edge: state SHALL become IDLE, counter 0, readdata 32'h0, error 0, all 64 array entries 32'h0.
REQ-026 reset SHALL have priority over all other inputs.
REQ-027 Reset during ACCESS SHALL abandon the access; no array write SHALL occur.
REQ-028 busywait SHALL be 0 in the cycle following reset while read and write are low.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), BLOCK_ADDR_W=6, BLOCK_W=32, DEPTH=64 and DEFAULT_LATENCY=5.
REQ-030 The latency countdown SHALL be a sub-module dmem_delay_counter (inputs: load, load value, enable; output: zero flag).
REQ-031 The block SHALL connect directly to the data cache controller's mem_read, mem_write, mem_address, mem_writedata, memReaddata and mem_busywait ports.

Verification
REQ-032 Write then read: write=1, address=6'h2A, writedata=32'hDEADBEEF held until busywait falls; then read=1 to 6'h2A -> busywait low exactly 5 cycles after each capture edge, readdata=32'hDEADBEEF.
REQ-033 Read after reset: read=1 to 6'h00 -> readdata=32'h0 at the DONE cycle; busywait high for cycles 1..5.
REQ-034 Illegal request: read=1 and write=1 in IDLE -> error pulse 1 cycle, busywait=0, array unchanged, readdata unchanged.
REQ-035 Mid-access reset: write to 6'h15 with 32'h12345678, reset high on the 3rd ACCESS edge -> IDLE next cycle; a subsequent read of 6'h15 returns 32'h0.
REQ-036 Input change mid-access: read 6'h01, address switched to 6'h02 during ACCESS -> readdata equals entry 6'h01.
REQ-037 Back-to-back: read held high through DONE -> new capture on the IDLE edge; busywait falls again 5 cycles later.
